// File: rtl/sockit_ghrd_debounced_pio_pkg.sv
// rtl/sockit_ghrd_debounced_pio_pkg.sv - register map and edge-mode encodings
package sockit_ghrd_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_RAW    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_MODE   = 3'd4;
  localparam logic [2:0] ADDR_PERIOD = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_ANY  = 2'b11;

endpackage

// File: rtl/sockit_ghrd_debounced_pio_if.sv
// rtl/sockit_ghrd_debounced_pio_if.sv - Avalon-MM slave bus plus interrupt line
interface sockit_ghrd_debounced_pio_if;

  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/sockit_ghrd_debounced_pio_debounce_bit.sv
// rtl/sockit_ghrd_debounced_pio_debounce_bit.sv - one input: synchroniser, debounce counter, edge qualify
module sockit_ghrd_pio_debounce_bit
  import sockit_ghrd_pio_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 20,
  parameter logic IDLE        = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             raw,
  input  logic [CNT_W-1:0] period,
  input  logic [1:0]       mode,
  output logic             stable,
  output logic             sync,
  output logic             edge_pulse
);

  localparam logic [CNT_W-1:0] ONE = 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_stable;
  logic                   r_stable_d;
  logic [CNT_W-1:0]       w_last;
  logic                   w_rise;
  logic                   w_fall;

  // Period 0 is treated as 1 so a change is still accepted after one cycle.
  assign w_last = (period == '0) ? '0 : period - ONE;

  // Metastability chain; resets to the idle level so release looks like no change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= {SYNC_STAGES{IDLE}};
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
  end

  assign sync = r_sync[SYNC_STAGES-1];

  // Count consecutive disagreeing cycles; accept the new level when the count reaches the period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_stable <= IDLE;
    end else if (sync == r_stable) begin
      r_cnt <= '0;
    end else if (r_cnt == w_last) begin
      r_cnt    <= '0;
      r_stable <= sync;
    end else begin
      r_cnt <= r_cnt + ONE;
    end
  end

  // Delayed copy of the debounced level, so the edge shows up the cycle after the flip.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_stable_d <= IDLE;
    else          r_stable_d <= r_stable;
  end

  assign stable     = r_stable;
  assign w_rise     = r_stable & ~r_stable_d;
  assign w_fall     = ~r_stable & r_stable_d;
  assign edge_pulse = (w_rise && (mode == EDGE_RISE || mode == EDGE_ANY)) ||
                      (w_fall && (mode == EDGE_FALL || mode == EDGE_ANY));

endmodule

// File: rtl/sockit_ghrd_debounced_pio.sv
// rtl/sockit_ghrd_debounced_pio.sv - debounced input PIO with edge capture and masked irq
module sockit_ghrd_debounced_pio
  import sockit_ghrd_pio_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               SYNC_STAGES   = 2,
  parameter int               CNT_W         = 20,
  parameter int               DEB_RST       = 50000,
  parameter logic [WIDTH-1:0] IDLE_LEVEL    = {WIDTH{1'b1}},
  parameter logic [1:0]       EDGE_MODE_RST = 2'b10
) (
  input  logic                        clk,
  input  logic                        reset_n,
  sockit_ghrd_debounced_pio_if.slave  bus,
  input  logic [WIDTH-1:0]            in_port
);

  logic [WIDTH-1:0]   r_mask;
  logic [WIDTH-1:0]   r_edge;
  logic [2*WIDTH-1:0] r_mode;
  logic [CNT_W-1:0]   r_period;
  logic [31:0]        r_readdata;

  logic [WIDTH-1:0]   w_stable;
  logic [WIDTH-1:0]   w_sync;
  logic [WIDTH-1:0]   w_edge_pulse;
  logic [WIDTH-1:0]   w_clear;
  logic [31:0]        w_rdata;
  logic               w_wr;
  logic               w_unused_wdata;

  // Upper writedata bits have no register behind them.
  assign w_unused_wdata = ^bus.writedata;

  assign w_wr = bus.chipselect && !bus.write_n;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sockit_ghrd_pio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .IDLE        (IDLE_LEVEL[g])
    ) u_deb (
      .clk        (clk),
      .reset_n    (reset_n),
      .raw        (in_port[g]),
      .period     (r_period),
      .mode       (r_mode[2*g+1:2*g]),
      .stable     (w_stable[g]),
      .sync       (w_sync[g]),
      .edge_pulse (w_edge_pulse[g])
    );
  end

  assign w_clear = (w_wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

  // Control registers; edge capture ORs new events in after the clear so none are lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask   <= '0;
      r_edge   <= '0;
      r_mode   <= {WIDTH{EDGE_MODE_RST}};
      r_period <= CNT_W'(DEB_RST);
    end else begin
      r_edge <= (r_edge & ~w_clear) | w_edge_pulse;
      if (w_wr && bus.address == ADDR_MASK)   r_mask   <= bus.writedata[WIDTH-1:0];
      if (w_wr && bus.address == ADDR_MODE)   r_mode   <= bus.writedata[2*WIDTH-1:0];
      if (w_wr && bus.address == ADDR_PERIOD) r_period <= bus.writedata[CNT_W-1:0];
    end
  end

  // Read mux, zero-extended; the reserved slot reads zero.
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_DATA:   w_rdata[WIDTH-1:0]   = w_stable;
      ADDR_RAW:    w_rdata[WIDTH-1:0]   = w_sync;
      ADDR_MASK:   w_rdata[WIDTH-1:0]   = r_mask;
      ADDR_EDGE:   w_rdata[WIDTH-1:0]   = r_edge;
      ADDR_MODE:   w_rdata[2*WIDTH-1:0] = r_mode;
      ADDR_PERIOD: w_rdata[CNT_W-1:0]   = r_period;
      ADDR_STATUS: w_rdata[WIDTH-1:0]   = r_edge & r_mask;
      default:     w_rdata              = '0;
    endcase
  end

  // Read data registered every cycle regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_readdata <= '0;
    else          r_readdata <= w_rdata;
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edge & r_mask);

endmodule

// File: tb/tb_sockit_ghrd_debounced_pio.sv
// tb/tb_sockit_ghrd_debounced_pio.sv - directed vector bench for the debounced PIO
module tb_sockit_ghrd_debounced_pio;

  localparam logic [2:0] A_DATA = 3'd0, A_RAW = 3'd1, A_MASK = 3'd2, A_EDGE = 3'd3,
                         A_MODE = 3'd4, A_PER = 3'd5, A_STAT = 3'd6, A_RSV = 3'd7;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] in_port;

  always #5 clk = ~clk;

  sockit_ghrd_debounced_pio_if bus ();

  sockit_ghrd_debounced_pio dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(posedge clk);
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    int          toggles;

    vecs[0]  = '{1'b0, A_DATA, 32'h0,        32'hF};
    vecs[1]  = '{1'b0, A_RAW,  32'h0,        32'hF};
    vecs[2]  = '{1'b0, A_MASK, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, A_EDGE, 32'h0,        32'h0};
    vecs[4]  = '{1'b0, A_MODE, 32'h0,        32'hAA};
    vecs[5]  = '{1'b0, A_PER,  32'h0,        32'd50000};
    vecs[6]  = '{1'b0, A_STAT, 32'h0,        32'h0};
    vecs[7]  = '{1'b0, A_RSV,  32'h0,        32'h0};
    vecs[8]  = '{1'b1, A_MASK, 32'hFFFFFFFF, 32'hF};
    vecs[9]  = '{1'b1, A_MODE, 32'hFFFFFFFF, 32'hFF};
    vecs[10] = '{1'b1, A_PER,  32'hFFFFFFFF, 32'hFFFFF};
    vecs[11] = '{1'b1, A_RSV,  32'hFFFFFFFF, 32'h0};
    vecs[12] = '{1'b1, A_DATA, 32'h0,        32'hF};
    vecs[13] = '{1'b1, A_EDGE, 32'hFFFFFFFF, 32'h0};
    vecs[14] = '{1'b1, A_STAT, 32'hFFFFFFFF, 32'h0};
    vecs[15] = '{1'b1, A_PER,  32'h4,        32'h4};
    vecs[16] = '{1'b1, A_MASK, 32'h1,        32'h1};
    vecs[17] = '{1'b1, A_MODE, 32'hAA,       32'hAA};

    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    in_port        = 4'hF;
    reset_n        = 1'b0;
    #1;
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_irq", 32'(bus.irq), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Register map: reset values, then write/readback with width masking.
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, d);
      check($sformatf("vec%0d_addr%0d", i, vecs[i].addr), d, vecs[i].exp);
    end
    check("irq_after_table", 32'(bus.irq), 32'h0);

    // Fall on bit 0 with period 4: irq exactly 2+4+1 cycles after the change.
    @(negedge clk);
    in_port[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      if (k == 6) check("lat_irq_cycle6", 32'(bus.irq), 32'h0);
      if (k == 7) check("lat_irq_cycle7", 32'(bus.irq), 32'h1);
    end
    read_check("lat_edge", A_EDGE, 32'h1);
    read_check("lat_status", A_STAT, 32'h1);
    read_check("lat_data", A_DATA, 32'hE);
    bus_write(A_EDGE, 32'h1);
    read_check("w1c_edge", A_EDGE, 32'h0);
    check("w1c_irq", 32'(bus.irq), 32'h0);

    // Bounce bit 1 with runs of 3 against a period of 8: nothing gets through.
    bus_write(A_PER, 32'd8);
    @(negedge clk);
    bus.address = A_DATA;
    @(posedge clk);
    toggles = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c < 40) in_port[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      else        in_port[1] = 1'b1;
      if (bus.readdata[1] !== 1'b1) toggles++;
    end
    check("bounce_toggles", 32'(toggles), 32'h0);
    read_check("bounce_edge", A_EDGE, 32'h0);
    read_check("bounce_data", A_DATA, 32'hE);

    // Bit 2 rise-only, bit 3 any-edge.
    bus_write(A_PER, 32'd4);
    bus_write(A_MODE, 32'hDA);
    @(negedge clk);
    in_port[3:2] = 2'b00;
    repeat (12) @(posedge clk);
    read_check("mode_fall_edge", A_EDGE, 32'h8);
    bus_write(A_EDGE, 32'h8);
    read_check("mode_w1c", A_EDGE, 32'h0);
    @(negedge clk);
    in_port[3:2] = 2'b11;
    repeat (12) @(posedge clk);
    read_check("mode_rise_edge", A_EDGE, 32'hC);
    bus_write(A_EDGE, 32'hC);
    read_check("mode_w1c2", A_EDGE, 32'h0);

    // Bit 0 (fall mode): rise is ignored, then a fall lands on the same edge as its W1C.
    @(negedge clk);
    in_port[0] = 1'b1;
    repeat (12) @(posedge clk);
    read_check("rise_ignored", A_EDGE, 32'h0);
    @(negedge clk);
    in_port[0] = 1'b0;
    repeat (6) @(posedge clk);
    bus_write(A_EDGE, 32'h1);
    read_check("set_wins", A_EDGE, 32'h1);
    bus_write(A_EDGE, 32'h2);
    read_check("w1c_other_bit", A_EDGE, 32'h1);

    // Asynchronous reset in the middle of a debounce count.
    bus_write(A_MASK, 32'h1);
    check("pre_reset_irq", 32'(bus.irq), 32'h1);
    bus_read(A_EDGE, d);
    check("pre_reset_rd", d, 32'h1);
    @(negedge clk);
    in_port[1] = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_irq", 32'(bus.irq), 32'h0);
    check("async_rst_rd", bus.readdata, 32'h0);
    in_port = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    read_check("post_rst_edge", A_EDGE, 32'h0);
    read_check("post_rst_data", A_DATA, 32'hF);
    read_check("post_rst_raw", A_RAW, 32'hF);
    read_check("post_rst_mask", A_MASK, 32'h0);
    read_check("post_rst_mode", A_MODE, 32'hAA);
    read_check("post_rst_period", A_PER, 32'd50000);
    check("post_rst_irq", 32'(bus.irq), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
